// File: rtl/gcd_job_sequencer_if.sv
// Bundles the job stream, result stream, GCD core link and status of gcd_job_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface gcd_job_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 10
) ();

  localparam int CNT_FIFO_W = $clog2(DEPTH) + 1;

  // Job stream
  logic                  job_valid;
  logic                  job_ready;
  logic [DATA_W-1:0]     job_a;
  logic [DATA_W-1:0]     job_b;
  logic [TAG_W-1:0]      job_tag;

  // Result stream
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_g;
  logic [TAG_W-1:0]      res_tag;
  logic [CNT_W-1:0]      res_cycles;

  // GCD core link
  logic [DATA_W-1:0]     gcd_a_in;
  logic [DATA_W-1:0]     gcd_b_in;
  logic                  gcd_input_valid;
  logic                  gcd_ack;
  logic [DATA_W-1:0]     gcd_g_out;
  logic                  gcd_output_valid;

  // Status
  logic [CNT_FIFO_W-1:0] fifo_count;
  logic                  idle;

  modport slave (
    input  job_valid, job_a, job_b, job_tag,
    output job_ready,
    output res_valid, res_g, res_tag, res_cycles,
    input  res_ready,
    output gcd_a_in, gcd_b_in, gcd_input_valid, gcd_ack,
    input  gcd_g_out, gcd_output_valid,
    output fifo_count, idle
  );

  modport master (
    output job_valid, job_a, job_b, job_tag,
    input  job_ready,
    input  res_valid, res_g, res_tag, res_cycles,
    output res_ready,
    input  gcd_a_in, gcd_b_in, gcd_input_valid, gcd_ack,
    output gcd_g_out, gcd_output_valid,
    input  fifo_count, idle
  );

endinterface

// File: rtl/gcd_job_sequencer.sv
// Job FIFO plus issue/wait/ack sequencer in front of an 8-bit GCD core; results are
// returned with their tag and the number of cycles the core spent busy.
module gcd_job_sequencer #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  gcd_job_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Job FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem_a   [DEPTH];
  logic [DATA_W-1:0] r_mem_b   [DEPTH];
  logic [TAG_W-1:0]  r_mem_tag [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // Issued job and result holding registers
  logic [DATA_W-1:0] r_gcd_a;
  logic [DATA_W-1:0] r_gcd_b;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_g;
  logic [TAG_W-1:0]  r_res_tag;
  logic [CNT_W-1:0]  r_res_cycles;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_capture;
  logic w_drain;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.job_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_drain   = r_res_valid && bus.res_ready;
  assign w_capture = (r_state == S_WAIT) && bus.gcd_output_valid
                     && (!r_res_valid || bus.res_ready);

  // NOTE: the FIFO payload array is deliberately left without reset; the pointers and
  // count fully define which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= bus.job_a;
      r_mem_b[r_wr_ptr]   <= bus.job_b;
      r_mem_tag[r_wr_ptr] <= bus.job_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next state gets its default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_capture) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands stay on the core inputs until the next pop; the counter freezes once the
  // core reports done, so backpressure does not inflate res_cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gcd_a <= '0;
      r_gcd_b <= '0;
      r_tag   <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_gcd_a <= r_mem_a[r_rd_ptr];
      r_gcd_b <= r_mem_b[r_rd_ptr];
      r_tag   <= r_mem_tag[r_rd_ptr];
      r_cnt   <= '0;
    end else if ((r_state == S_WAIT) && !bus.gcd_output_valid && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A capture in the same cycle as a drain refills the holding register without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_valid  <= 1'b0;
      r_res_g      <= '0;
      r_res_tag    <= '0;
      r_res_cycles <= '0;
    end else if (w_capture) begin
      r_res_valid  <= 1'b1;
      r_res_g      <= bus.gcd_g_out;
      r_res_tag    <= r_tag;
      r_res_cycles <= r_cnt;
    end else if (w_drain) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign bus.job_ready       = !w_full;
  assign bus.fifo_count      = r_count;
  assign bus.idle            = (r_state == S_IDLE) && w_empty;
  assign bus.gcd_a_in        = r_gcd_a;
  assign bus.gcd_b_in        = r_gcd_b;
  assign bus.gcd_input_valid = (r_state == S_ISSUE);
  assign bus.gcd_ack         = (r_state == S_ACK);
  assign bus.res_valid       = r_res_valid;
  assign bus.res_g           = r_res_g;
  assign bus.res_tag         = r_res_tag;
  assign bus.res_cycles      = r_res_cycles;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed and randomised bench for gcd_job_sequencer with a behavioural Euclid GCD core
// and an in-order result scoreboard.
module tb_gcd_job_sequencer;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_job_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  gcd_job_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural GCD core: IDLE -> BUSY (one Euclid step per cycle) -> DONE until acked
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} core_st_t;
  core_st_t          core_st;
  logic [DATA_W-1:0] core_a, core_b, core_g;
  logic              core_ov;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_st <= C_IDLE;
      core_a  <= '0;
      core_b  <= '0;
      core_g  <= '0;
      core_ov <= 1'b0;
    end else begin
      case (core_st)
        C_IDLE: if (bus.gcd_input_valid) begin
          core_a  <= bus.gcd_a_in;
          core_b  <= bus.gcd_b_in;
          core_st <= C_BUSY;
        end
        C_BUSY: if (core_b == 0) begin
          core_g  <= core_a;
          core_ov <= 1'b1;
          core_st <= C_DONE;
        end else begin
          core_a <= core_b;
          core_b <= core_a % core_b;
        end
        C_DONE: if (bus.gcd_ack) begin
          core_ov <= 1'b0;
          core_st <= C_IDLE;
        end
        default: core_st <= C_IDLE;
      endcase
    end
  end

  assign bus.gcd_g_out        = core_g;
  assign bus.gcd_output_valid = core_ov;

  typedef struct {
    logic [DATA_W-1:0] g;
    logic [TAG_W-1:0]  tag;
    logic [CNT_W-1:0]  cycles;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_iv  = 0;
  int n_ack = 0;
  int n_res = 0;
  logic saw_full = 1'b0;
  logic [DATA_W-1:0] last_g;
  logic [TAG_W-1:0]  last_tag;
  logic [CNT_W-1:0]  last_cycles;
  logic              hold_valid = 1'b0;
  logic [DATA_W+TAG_W+CNT_W-1:0] hold_data;

  function automatic logic [DATA_W-1:0] ref_gcd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Busy cycles of the model core: one per Euclid step plus the cycle that sees b == 0
  function automatic logic [CNT_W-1:0] ref_cycles(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] t;
    logic [CNT_W-1:0]  n;
    n = 1;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
      n = n + 1;
    end
    return n;
  endfunction

  // Protocol checker, result stability and in-order scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else begin
      if (bus.gcd_input_valid) begin
        n_iv++;
        n_cmp++;
        if (core_st != C_IDLE || bus.gcd_ack) begin
          n_err++;
          $display("FAIL input_valid_legal: core_st=%0d ack=%0b, required core idle and ack low", core_st, bus.gcd_ack);
        end
      end
      if (bus.gcd_ack) begin
        n_ack++;
        n_cmp++;
        if (core_st != C_DONE) begin
          n_err++;
          $display("FAIL ack_legal: core_st=%0d, required DONE(%0d)", core_st, C_DONE);
        end
      end
      if (hold_valid) begin
        n_cmp++;
        if (!bus.res_valid || {bus.res_g, bus.res_tag, bus.res_cycles} !== hold_data) begin
          n_err++;
          $display("FAIL res_stable: valid=%0b data=%h, required valid=1 data=%h",
                   bus.res_valid, {bus.res_g, bus.res_tag, bus.res_cycles}, hold_data);
        end
      end
      hold_valid = bus.res_valid && !bus.res_ready;
      hold_data  = {bus.res_g, bus.res_tag, bus.res_cycles};
      if (bus.res_valid && bus.res_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: g=%0d tag=%0d with no job outstanding", bus.res_g, bus.res_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.res_g !== e.g || bus.res_tag !== e.tag || bus.res_cycles !== e.cycles) begin
            n_err++;
            $display("FAIL result: g=%0d tag=%0d cycles=%0d, required g=%0d tag=%0d cycles=%0d",
                     bus.res_g, bus.res_tag, bus.res_cycles, e.g, e.tag, e.cycles);
          end
          n_res++;
          last_g      = bus.res_g;
          last_tag    = bus.res_tag;
          last_cycles = bus.res_cycles;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] exp_g);
    exp_t e;
    logic accepted;
    accepted      = 1'b0;
    bus.job_valid = 1'b1;
    bus.job_a     = a;
    bus.job_b     = b;
    bus.job_tag   = tag;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (bus.job_ready) begin
        accepted = 1'b1;
      end else begin
        saw_full = 1'b1;
        n_cmp++;
        if (bus.fifo_count !== 3'(DEPTH)) begin
          n_err++;
          $display("FAIL ready_vs_count: job_ready=0 at fifo_count=%0d, required %0d", bus.fifo_count, DEPTH);
        end
      end
      @(posedge clk);
      #1;
    end
    if (accepted) begin
      e.g      = exp_g;
      e.tag    = tag;
      e.cycles = ref_cycles(a, b);
      exp_q.push_back(e);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: job tag %0d not accepted in 200 cycles", tag);
    end
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    logic done;
    done = 1'b0;
    for (int t = 0; t < limit && !done; t++) begin
      tick();
      done = (exp_q.size() == 0) && bus.idle && !bus.res_valid;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", exp_q.size(), limit);
    end
  endtask

  task automatic test_reset();
    bus.job_valid = 1'b0;
    bus.job_a     = '0;
    bus.job_b     = '0;
    bus.job_tag   = '0;
    bus.res_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.res_valid, bus.gcd_input_valid, bus.gcd_ack, bus.fifo_count, bus.idle, bus.job_ready} !== 8'b000_000_1_1) begin
      n_err++;
      $display("FAIL reset_ctrl: rv/iv/ack/count/idle/ready=%b, required 00000011",
               {bus.res_valid, bus.gcd_input_valid, bus.gcd_ack, bus.fifo_count, bus.idle, bus.job_ready});
    end
    n_cmp++;
    if ({bus.gcd_a_in, bus.gcd_b_in, bus.res_g, bus.res_tag, bus.res_cycles} !== '0) begin
      n_err++;
      $display("FAIL reset_data: a_in=%0d b_in=%0d g=%0d tag=%0d cycles=%0d, required all 0",
               bus.gcd_a_in, bus.gcd_b_in, bus.res_g, bus.res_tag, bus.res_cycles);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    int iv0, ack0, r0;
    iv0 = n_iv; ack0 = n_ack; r0 = n_res;
    bus.res_ready = 1'b1;
    push_job(8'd12, 8'd8, 4'd3, 8'd4);
    wait_drain(100);
    n_cmp++;
    if (last_g !== 8'd4 || last_tag !== 4'd3) begin
      n_err++;
      $display("FAIL single_result: g=%0d tag=%0d, required g=4 tag=3", last_g, last_tag);
    end
    n_cmp++;
    if (n_iv - iv0 != 1 || n_ack - ack0 != 1 || n_res - r0 != 1) begin
      n_err++;
      $display("FAIL single_pulses: iv=%0d ack=%0d res=%0d, required 1 each", n_iv - iv0, n_ack - ack0, n_res - r0);
    end
    n_cmp++;
    if (bus.gcd_a_in !== 8'd12 || bus.gcd_b_in !== 8'd8) begin
      n_err++;
      $display("FAIL operand_hold: a_in=%0d b_in=%0d, required 12 8", bus.gcd_a_in, bus.gcd_b_in);
    end
  endtask

  task automatic test_zero_operands();
    bus.res_ready = 1'b1;
    push_job(8'd9, 8'd0, 4'd1, 8'd9);
    wait_drain(100);
    n_cmp++;
    if (last_g !== 8'd9 || last_cycles !== 10'd1) begin
      n_err++;
      $display("FAIL zero_b: g=%0d cycles=%0d, required g=9 cycles=1", last_g, last_cycles);
    end
    push_job(8'd0, 8'd7, 4'd2, 8'd7);
    wait_drain(100);
    n_cmp++;
    if (last_g !== 8'd7) begin
      n_err++;
      $display("FAIL zero_a: g=%0d, required 7", last_g);
    end
    push_job(8'd0, 8'd0, 4'd4, 8'd0);
    wait_drain(100);
    n_cmp++;
    if (last_g !== 8'd0 || last_tag !== 4'd4) begin
      n_err++;
      $display("FAIL zero_both: g=%0d tag=%0d, required g=0 tag=4", last_g, last_tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] va [6] = '{8'd12, 8'd100, 8'd81, 8'd35, 8'd17, 8'd240};
    logic [DATA_W-1:0] vb [6] = '{8'd8,  8'd75,  8'd27, 8'd14, 8'd5,  8'd96};
    logic [DATA_W-1:0] vg [6] = '{8'd4,  8'd25,  8'd27, 8'd7,  8'd1,  8'd48};
    int iv0, ack0, r0;
    iv0 = n_iv; ack0 = n_ack; r0 = n_res;
    bus.res_ready = 1'b1;
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_job(va[i], vb[i], 4'(i), vg[i]);
    end
    wait_drain(300);
    n_cmp++;
    if (saw_full !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_full: job_ready never dropped, required low at count %0d", DEPTH);
    end
    n_cmp++;
    if (n_iv - iv0 != 6 || n_ack - ack0 != 6 || n_res - r0 != 6) begin
      n_err++;
      $display("FAIL b2b_counts: iv=%0d ack=%0d res=%0d, required 6 each", n_iv - iv0, n_ack - ack0, n_res - r0);
    end
  endtask

  task automatic test_backpressure();
    int ack0;
    logic seen;
    bus.res_ready = 1'b0;
    push_job(8'd12, 8'd8, 4'd7, 8'd4);
    push_job(8'd100, 8'd75, 4'd8, 8'd25);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      seen = bus.res_valid;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL bp_first: res_valid=0 after 100 cycles, required 1");
    end
    repeat (5) tick();
    ack0 = n_ack;
    repeat (50) tick();
    n_cmp++;
    if (n_ack != ack0 || bus.res_valid !== 1'b1 || bus.res_tag !== 4'd7 || core_ov !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold: acks=%0d rv=%0b tag=%0d core_done=%0b, required acks=0 rv=1 tag=7 core_done=1",
               n_ack - ack0, bus.res_valid, bus.res_tag, core_ov);
    end
    bus.res_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd8 || bus.res_g !== 8'd25 || bus.gcd_ack !== 1'b1) begin
      n_err++;
      $display("FAIL bp_refill: rv=%0b tag=%0d g=%0d ack=%0b, required rv=1 tag=8 g=25 ack=1",
               bus.res_valid, bus.res_tag, bus.res_g, bus.gcd_ack);
    end
    wait_drain(100);
  endtask

  task automatic test_reset_mid_job();
    int ack0, iv0;
    bus.res_ready = 1'b1;
    push_job(8'd233, 8'd144, 4'd1, 8'd1);
    push_job(8'd21, 8'd14, 4'd2, 8'd7);
    push_job(8'd12, 8'd8, 4'd3, 8'd4);
    push_job(8'd9, 8'd0, 4'd4, 8'd9);
    n_cmp++;
    if (bus.fifo_count !== 3'd3 || core_st != C_BUSY) begin
      n_err++;
      $display("FAIL pre_reset: fifo_count=%0d core_st=%0d, required 3 and BUSY", bus.fifo_count, core_st);
    end
    reset = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    ack0 = n_ack;
    iv0  = n_iv;
    @(negedge clk);
    n_cmp++;
    if ({bus.res_valid, bus.gcd_input_valid, bus.gcd_ack, bus.fifo_count, bus.idle} !== 7'b000_000_1) begin
      n_err++;
      $display("FAIL post_reset_ctrl: rv/iv/ack/count/idle=%b, required 0000001",
               {bus.res_valid, bus.gcd_input_valid, bus.gcd_ack, bus.fifo_count, bus.idle});
    end
    n_cmp++;
    if ({bus.gcd_a_in, bus.gcd_b_in, bus.res_g, bus.res_tag, bus.res_cycles} !== '0) begin
      n_err++;
      $display("FAIL post_reset_data: a_in=%0d b_in=%0d g=%0d, required 0", bus.gcd_a_in, bus.gcd_b_in, bus.res_g);
    end
    @(posedge clk);
    #1;
    repeat (10) tick();
    n_cmp++;
    if (n_ack != ack0 || n_iv != iv0) begin
      n_err++;
      $display("FAIL stray_pulse: acks=%0d ivs=%0d after reset, required 0", n_ack - ack0, n_iv - iv0);
    end
    push_job(8'd21, 8'd14, 4'd5, 8'd7);
    wait_drain(100);
    n_cmp++;
    if (last_g !== 8'd7 || last_tag !== 4'd5) begin
      n_err++;
      $display("FAIL after_reset_job: g=%0d tag=%0d, required g=7 tag=5", last_g, last_tag);
    end
  endtask

  task automatic test_random();
    int iv0, ack0, r0;
    logic prod_done;
    iv0 = n_iv; ack0 = n_ack; r0 = n_res;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [DATA_W-1:0] a, b;
          a = DATA_W'($urandom_range(0, 255));
          b = DATA_W'($urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) tick();
          push_job(a, b, TAG_W'(i), ref_gcd(a, b));
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          bus.res_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    bus.res_ready = 1'b1;
    wait_drain(500);
    n_cmp++;
    if (n_iv - iv0 != 1000 || n_ack - ack0 != 1000 || n_res - r0 != 1000) begin
      n_err++;
      $display("FAIL random_counts: iv=%0d ack=%0d res=%0d, required 1000 each", n_iv - iv0, n_ack - ack0, n_res - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_operands();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
